// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer.
// Detects instruction retirement from a change in the program counter and
// queues {retired pc, retired inst, sequence number} records in a
// first-word-fall-through FIFO. When the FIFO is full and nothing is popped,
// the record is dropped, a sticky overflow flag is set and a saturating drop
// counter is bumped. The sequence number advances on every push attempt, so
// gaps in the drained stream show where records were lost.
module retire_trace_buffer #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic                     trace_en,
  input  logic                     clear_ovf,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc_prev;
  logic [31:0]   r_inst_prev;
  logic [31:0]   r_seq;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_seq  [DEPTH];

  logic w_retire;
  logic w_push_req;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_head_valid;

  assign w_retire     = (pc != r_pc_prev);
  assign w_push_req   = w_retire & trace_en;
  assign w_full       = (r_count == CW'(DEPTH));
  // out_ready only matters while a record is being presented.
  assign w_pop        = (r_count != '0) & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push       = w_push_req & (~w_full | w_pop);
  assign w_drop       = w_push_req & w_full & ~w_pop;
  // Outputs are forced to zero while reset is held, not just after its edge.
  assign w_head_valid = reset & (r_count != '0);

  // Retirement tracking, sequence numbering, pointers, occupancy and drop status.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc_prev   <= RESET_PC;
      r_inst_prev <= '0;
      r_seq       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_retire) begin
        r_pc_prev   <= pc;
        r_inst_prev <= inst;
      end
      if (w_push_req) r_seq <= r_seq + 32'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear wins: the flag stays up and the
      // counter restarts at one so the new loss is not hidden.
      if (w_drop) r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
      if (w_drop && clear_ovf) r_drop_cnt <= 16'd1;
      else if (clear_ovf) r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_pc_prev;
      r_mem_inst[r_wr_ptr] <= r_inst_prev;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  assign out_valid = w_head_valid;
  assign out_pc    = w_head_valid ? r_mem_pc[r_rd_ptr]   : '0;
  assign out_inst  = w_head_valid ? r_mem_inst[r_rd_ptr] : '0;
  assign out_seq   = w_head_valid ? r_mem_seq[r_rd_ptr]  : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: doc/retire_trace_buffer.md
RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; power of two, at least 2.
REQ-002 Parameter RESET_PC, default 32'h00400000, meaning the pc value before the first fetch.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port pc, input, 32 bits: current CPU program counter.
REQ-006 Port inst, input, 32 bits: instruction at pc.
REQ-007 Port trace_en, input, 1 bit: 1 = record retirements.
REQ-008 Port clear_ovf, input, 1 bit: clears the overflow status.
REQ-009 Port out_ready, input, 1 bit: consumer accepts the head record.
REQ-010 Port out_valid, output, 1 bit: the head record is valid.
REQ-011 Port out_pc, output, 32 bits: retired pc of the head record.
REQ-012 Port out_inst, output, 32 bits: retired instruction of the head record.
REQ-013 Port out_seq, output, 32 bits: retirement sequence number of the head record.
REQ-014 Port count, output, clog2(DEPTH)+1 bits: number of FIFO entries occupied.
REQ-015 Port overflow, output, 1 bit: sticky flag; a record was dropped.
REQ-016 Port drop_cnt, output, 16 bits: number of dropped records.

Function
REQ-017 The block SHALL keep the registers pc_prev and inst_prev.
REQ-018 A retirement SHALL be detected in any non-reset cycle where pc != pc_prev.
REQ-019 On a retirement, the block SHALL load pc_prev<=pc and inst_prev<=inst whatever the state of trace_en.
REQ-020 A push SHALL occur when a retirement is detected and trace_en=1.
REQ-021 The pushed record SHALL be {pc_prev, inst_prev, seq}, using the old pc_prev/inst_prev values.
REQ-022 seq SHALL increment by 1 (mod 2^32) on every push attempt, including dropped ones, so gaps expose drops.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-024 out_ready SHALL be ignored when out_valid=0.
REQ-025 The FIFO SHALL be first-word-fall-through.
REQ-026 out_valid SHALL equal (count != 0).
REQ-027 out_pc, out_inst and out_seq SHALL show the head entry whenever out_valid=1.
REQ-028 out_pc, out_inst and out_seq SHALL hold 0 when the FIFO is empty.
REQ-029 Latency: a record pushed at edge N SHALL appear at the outputs after edge N when the FIFO was empty at N.
REQ-030 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-031 count SHALL update as +1 on a push, -1 on a pop, and unchanged on both or neither.
REQ-032 Push and pop in the same cycle on a full FIFO SHALL both succeed; count stays DEPTH.
REQ-033 Push on a full FIFO without a pop SHALL drop the record, set overflow=1, and increment drop_cnt, saturating at 16'hFFFF.
REQ-034 Push on an empty FIFO with out_ready=1 SHALL NOT bypass; the record becomes visible the next cycle.
REQ-035 clear_ovf=1 SHALL clear overflow and drop_cnt at the next edge.
REQ-036 If clear_ovf=1 coincides with a drop, overflow SHALL be 1 and drop_cnt SHALL be 1 after the edge.
REQ-037 A change of trace_en SHALL take effect in the same cycle; in-flight FIFO contents are unaffected.

Reset
REQ-038 When reset=0 at a rising edge, the block SHALL set pc_prev=RESET_PC, inst_prev=0, seq=0, both pointers=0, count=0, overflow=0 and drop_cnt=0.
REQ-039 During reset, out_valid and the out_* data outputs SHALL be 0.
REQ-040 Reset asserted mid-operation SHALL discard all FIFO contents.
REQ-041 No push SHALL be recorded in a cycle where reset=0.

Verification
REQ-042 Basic push: reset, then pc changes 00400000->00400004 with inst=3c010000 and trace_en=1, out_ready=0 -> next cycle out_valid=1, out_pc=00400000, out_inst=00000000, out_seq=0, count=1.
REQ-043 Stable pc: pc is held at 00400004 for 5 cycles -> no push; count stays 1.
REQ-044 Fill and overflow: DEPTH+3 retirements with out_ready=0 -> count=16, overflow=1, drop_cnt=3; then drain -> out_seq runs 0..15 in order, out_valid=0 afterwards.
REQ-045 Full with simultaneous push/pop: on a full FIFO, one retirement with out_ready=1 -> count stays 16, no drop, head advances to seq 1, tail holds seq 16.
REQ-046 Gating and clear: trace_en=0 over 4 pc changes -> count unchanged, seq unchanged; then clear_ovf=1 -> overflow=0, drop_cnt=0.
REQ-047 Mid-run reset: reset=0 for 1 cycle while count=5 -> count=0, out_valid=0; the next retirement has out_seq=0 and out_pc=00400000.
